instruction_fetch_unit: RTL and testbench

- Fetch/decode front end of the mini-CPU; sits directly upstream of the combinational instruction ROM.
- Drives the ROM address from a 16-bit program counter and registers the returned 28-bit instruction into decoded fields for the execute/ALU stage.
- Executes NOP in place as a timed delay using its 24-bit count field. Honours stall and branch-redirect requests from execute.

---
 rtl/cpu_isa_pkg.sv | 55 +++++
 rtl/instruction_fetch_unit_if.sv | 31 +++
 rtl/nop_delay_counter.sv | 36 +++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants and shared types for the mini-CPU front end.
package cpu_isa_pkg;

   localparam int ADDR_W  = 16;
   localparam int INSTR_W = 28;
   localparam int OP_W    = 4;
   localparam int CNT_W   = 24;

   // Instruction field positions
   localparam int OP_MSB   = 27;
   localparam int OP_LSB   = 24;
   localparam int DEST_MSB = 23;
   localparam int DEST_LSB = 16;
   localparam int SRC1_MSB = 15;
   localparam int SRC1_LSB = 8;
   localparam int SRC0_MSB = 7;
   localparam int SRC0_LSB = 0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 4'd0,
      OP_STO = 4'd1,
      OP_LCD = 4'd2,
      OP_ADD = 4'd3,
      OP_SUB = 4'd4,
      OP_BLE = 4'd5,
      OP_JMP = 4'd6
   } opcode_e;

   localparam logic [OP_W-1:0] NOP_OPCODE = OP_NOP;

   localparam logic [7:0] R0 = 8'd0;
   localparam logic [7:0] R1 = 8'd1;
   localparam logic [7:0] R2 = 8'd2;
   localparam logic [7:0] R3 = 8'd3;
   localparam logic [7:0] R4 = 8'd4;
   localparam logic [7:0] R5 = 8'd5;
   localparam logic [7:0] R6 = 8'd6;
   localparam logic [7:0] R7 = 8'd7;
   localparam logic [7:0] R8 = 8'd8;

   // Decoded view of one instruction word; imm overlays {src1, src0}
   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [7:0]      dest;
      logic [7:0]      src1;
      logic [7:0]      src0;
   } instr_t;

   typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} fetch_state_e;

   function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
      return instr[OP_MSB:OP_LSB] == NOP_OPCODE;
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: ROM address/data plus execute-stage control and decoded outputs.
interface instruction_fetch_unit_if;
   import cpu_isa_pkg::*;

   logic [ADDR_W-1:0]  oAddress;
   logic [INSTR_W-1:0] iInstruction;
   logic               iStall;
   logic               iBranchTaken;
   logic [ADDR_W-1:0]  iBranchTarget;
   logic               oValid;
   logic [OP_W-1:0]    oOpcode;
   logic [7:0]         oDest;
   logic [7:0]         oSrc1;
   logic [7:0]         oSrc0;
   logic [15:0]        oImm;
   logic [ADDR_W-1:0]  oPC;
   logic               oBusy;

   // Fetch unit side
   modport master (
      output oAddress, oValid, oOpcode, oDest, oSrc1, oSrc0, oImm, oPC, oBusy,
      input  iInstruction, iStall, iBranchTaken, iBranchTarget
   );

   // ROM / execute side
   modport slave (
      input  oAddress, oValid, oOpcode, oDest, oSrc1, oSrc0, oImm, oPC, oBusy,
      output iInstruction, iStall, iBranchTaken, iBranchTarget
   );

endinterface

// File: rtl/nop_delay_counter.sv
// Loadable down-counter timing the idle edges of a NOP.
module nop_delay_counter
   import cpu_isa_pkg::*;
(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Last idle edge is the one where the count reads 1
   assign done_o = en_i && (cnt_q == CNT_W'(1));

   // Next count: clear beats load beats decrement; holds when disabled (stall)
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (load_i)
         cnt_d = load_val_i;
      else if (en_i)
         cnt_d = done_o ? '0 : cnt_q - CNT_W'(1);
   end

   // Count register
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode front end: drives ROM address from PC, registers decoded
// fields, runs NOPs as timed idle periods, honours stall and branch redirect.
module instruction_fetch_unit
   import cpu_isa_pkg::*;
(
   input  logic                      Clock,
   input  logic                      Reset,
   instruction_fetch_unit_if.master  bus
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] opc_q, opc_d;
   logic              valid_q, valid_d;
   instr_t            fld_q, fld_d;

   logic              cnt_clr, cnt_load, cnt_en, cnt_done;
   logic [CNT_W-1:0]  nop_len;
   logic              fetched_nop;

   assign nop_len     = bus.iInstruction[CNT_W-1:0];
   assign fetched_nop = is_nop(bus.iInstruction);

   nop_delay_counter u_delay (
      .Clock      (Clock),
      .Reset      (Reset),
      .clear_i    (cnt_clr),
      .load_i     (cnt_load),
      .load_val_i (nop_len),
      .en_i       (cnt_en),
      .done_o     (cnt_done)
   );

   // Next state: branch wins over stall and WAIT; stall freezes everything
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      opc_d    = opc_q;
      valid_d  = valid_q;
      fld_d    = fld_q;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      if (bus.iBranchTaken) begin
         // Flushed slot: fields keep their last contents, only valid drops
         pc_d    = bus.iBranchTarget;
         valid_d = 1'b0;
         state_d = ST_RUN;
         cnt_clr = 1'b1;
      end else if (!bus.iStall) begin
         case (state_q)
            ST_RUN: begin
               fld_d   = instr_t'(bus.iInstruction);
               opc_d   = pc_q;
               pc_d    = pc_q + ADDR_W'(1);
               valid_d = !fetched_nop;
               // A zero-length NOP is just the single bubble of its own fetch
               if (fetched_nop && (nop_len != '0)) begin
                  cnt_load = 1'b1;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               valid_d = 1'b0;
               cnt_en  = 1'b1;
               if (cnt_done) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
         opc_q   <= '0;
         valid_q <= 1'b0;
         fld_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         opc_q   <= opc_d;
         valid_q <= valid_d;
         fld_q   <= fld_d;
      end
   end

   assign bus.oAddress = pc_q;
   assign bus.oValid   = valid_q;
   assign bus.oOpcode  = fld_q.op;
   assign bus.oDest    = fld_q.dest;
   assign bus.oSrc1    = fld_q.src1;
   assign bus.oSrc0    = fld_q.src0;
   assign bus.oImm     = {fld_q.src1, fld_q.src0};
   assign bus.oPC      = opc_q;
   assign bus.oBusy    = (state_q == ST_WAIT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed ROM program plus
// randomized stall/branch traffic against a cycle-level behavioural model.
module tb_instruction_fetch_unit;
   import cpu_isa_pkg::*;

   typedef struct packed {
      logic [15:0] addr;
      logic        valid;
      logic [3:0]  op;
      logic [7:0]  dest;
      logic [7:0]  src1;
      logic [7:0]  src0;
      logic [15:0] imm;
      logic [15:0] pc;
      logic        busy;
   } obs_t;

   logic Clock = 1'b0;
   logic Reset = 1'b0;
   always #5 Clock = ~Clock;

   instruction_fetch_unit_if bus ();
   instruction_fetch_unit dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   logic [27:0] rom [0:65535];
   assign bus.iInstruction = rom[bus.oAddress];

   int   checks = 0;
   int   errors = 0;
   int   busy_cnt;
   obs_t sb [$];

   // Behavioural model: current PC, idle edges still owed, visible outputs
   logic [15:0] m_pc;
   int          m_idle;
   obs_t        m_o;

   function automatic obs_t sample();
      obs_t a;
      a.addr  = bus.oAddress;  a.valid = bus.oValid;  a.op   = bus.oOpcode;
      a.dest  = bus.oDest;     a.src1  = bus.oSrc1;   a.src0 = bus.oSrc0;
      a.imm   = bus.oImm;      a.pc    = bus.oPC;     a.busy = bus.oBusy;
      return a;
   endfunction

   task automatic model_reset();
      m_pc = '0; m_idle = 0; m_o = '0;
   endtask

   task automatic model_edge(input logic st, input logic br, input logic [15:0] tgt);
      logic [27:0] ins;
      if (br) begin
         m_pc = tgt; m_idle = 0; m_o.valid = 1'b0;
      end else if (!st) begin
         if (m_idle > 0) m_idle--;
         else begin
            ins       = rom[m_pc];
            m_o.op    = ins[27:24];
            m_o.dest  = ins[23:16];
            m_o.src1  = ins[15:8];
            m_o.src0  = ins[7:0];
            m_o.imm   = ins[15:0];
            m_o.pc    = m_pc;
            m_o.valid = (ins[27:24] != 4'd0);
            if (!m_o.valid) m_idle = int'(ins[23:0]);
            m_pc = m_pc + 16'd1;
         end
      end
      m_o.addr = m_pc;
      m_o.busy = (m_idle > 0);
   endtask

   // One clock: drive inputs, let the edge happen, predict, queue the prediction
   task automatic step(input logic st, input logic br = 1'b0, input logic [15:0] tgt = 16'h0);
      @(negedge Clock); #1;
      bus.iStall = st; bus.iBranchTaken = br; bus.iBranchTarget = tgt;
      @(posedge Clock);
      model_edge(st, br, tgt);
      sb.push_back(m_o);
      #1;
      if (bus.oBusy) busy_cnt++;
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      obs_t a;
      a = sample();
      checks++;
      if (a !== '0) begin
         errors++;
         $display("FAIL %s: got %h expected all zero", name, a);
      end
   endtask

   // Monitor: compares DUT outputs with the oldest prediction, away from the edge
   always @(negedge Clock) begin
      if (sb.size() > 0) begin
         obs_t e, a;
         e = sb.pop_front();
         a = sample();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs @%0t: got addr=%h v=%b op=%h d=%h s1=%h s0=%h imm=%h pc=%h busy=%b expected addr=%h v=%b op=%h d=%h s1=%h s0=%h imm=%h pc=%h busy=%b",
                     $time, a.addr, a.valid, a.op, a.dest, a.src1, a.src0, a.imm, a.pc, a.busy,
                     e.addr, e.valid, e.op, e.dest, e.src1, e.src0, e.imm, e.pc, e.busy);
         end
      end
   end

   initial begin
      logic [3:0] op;
      bus.iStall = 1'b0; bus.iBranchTaken = 1'b0; bus.iBranchTarget = '0;
      for (int i = 0; i < 65536; i++)
         rom[i] = {OP_ADD, R1, 8'(i), 8'(i >> 8)};
      rom[0]  = {OP_STO, R7, 16'h00FF};
      rom[1]  = {OP_LCD, R5, R4, R3};
      rom[2]  = {OP_SUB, R2, R1, R0};
      rom[5]  = {OP_NOP, 24'd4000};
      rom[6]  = {OP_JMP, R8, 16'hBEEF};
      rom[10] = {OP_NOP, 24'd0};
      rom[14] = {OP_NOP, 24'd10};
      rom[16'h20] = {OP_SUB, R6, R5, R4};
      rom[16'h22] = {OP_NOP, 24'd50};
      rom[16'hFFFF] = {OP_BLE, R3, R2, R1};
      rom[16'h300] = {OP_NOP, 24'd2500};
      for (int i = 16'h100; i < 16'h200; i++) begin
         op = 4'($urandom_range(0, 6));
         rom[i] = (op == 4'd0) ? {4'd0, 24'($urandom_range(0, 6))} : {op, 24'($urandom)};
      end

      // Reset state
      model_reset();
      #3 check_zero("reset_state");
      @(posedge Clock); #2 Reset = 1'b1;

      // Program start, then the 4000-cycle NOP at address 5
      busy_cnt = 0;
      repeat (4007) step(1'b0);
      check_val("nop4000_busy_cycles", busy_cnt, 4000);

      // Stall mid-stream and a zero-length NOP
      busy_cnt = 0;
      repeat (2) step(1'b0);
      repeat (3) step(1'b1);
      repeat (5) step(1'b0);
      check_val("nop0_busy_cycles", busy_cnt, 0);

      // NOP 10 with a 3-cycle stall inside the wait
      busy_cnt = 0;
      repeat (5) step(1'b0);
      repeat (3) step(1'b1);
      for (int i = 0; i < 20; i++) begin
         if (m_idle == 0) break;
         step(1'b0);
      end
      check_val("nop10_stalled_busy_cycles", busy_cnt, 13);

      // Branch together with stall, then branch from WAIT
      step(1'b1, 1'b1, 16'h0020);
      repeat (3) step(1'b0);
      repeat (5) step(1'b0);
      step(1'b0, 1'b1, 16'h0020);
      repeat (2) step(1'b0);

      // Branch to the top of the address space and wrap
      step(1'b0, 1'b1, 16'hFFFF);
      repeat (3) step(1'b0);

      // Random stall/branch traffic over a region with short NOPs
      step(1'b0, 1'b1, 16'h0100);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              16'h0100 + 16'($urandom_range(0, 255)));

      // Asynchronous reset in the middle of a long wait (counter at 2000)
      step(1'b0, 1'b1, 16'h0300);
      repeat (501) step(1'b0);
      check_val("pre_reset_idle_left", m_idle, 2000);
      #1 Reset = 1'b0;
      sb.delete();
      #1 check_zero("async_reset_mid_wait");
      repeat (2) @(posedge Clock);
      #2 Reset = 1'b1;
      model_reset();
      busy_cnt = 0;
      repeat (4) step(1'b0);
      check_val("post_reset_busy_cycles", busy_cnt, 0);

      @(negedge Clock); #1;
      check_val("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
